// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between fetch and data access.
// Latency: request sampled in N, mem_req in N+1, valid in the cycle after mem_ack (min N+2).
// Backpressure: requests wait while the memory is busy; stall holds the pipeline until each is served.
module mem_port_arbiter #(
    parameter int IADDR_W  = 8,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [IADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0]  if_rdata,
    output logic               if_valid,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [ADDR_W-1:0]  d_addr,
    input  logic [DATA_W-1:0]  d_wdata,
    output logic [DATA_W-1:0]  d_rdata,
    output logic               d_valid,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack,
    output logic               stall,
    output logic               timeout_err
);
    typedef enum logic [1:0] {S_IDLE, S_BUSY_I, S_BUSY_D} state_t;

    localparam logic [7:0] LP_MAX_WAIT = 8'(MAX_WAIT);

    state_t              r_state, w_state_nxt;
    logic                r_last_d, w_last_d_nxt;
    logic [7:0]          r_wait_cnt, w_wait_cnt_nxt;
    logic                r_mem_req, w_mem_req_nxt;
    logic                r_mem_we, w_mem_we_nxt;
    logic [ADDR_W-1:0]   r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
    logic [DATA_W-1:0]   r_if_rdata, w_if_rdata_nxt;
    logic                r_if_valid, w_if_valid_nxt;
    logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_nxt;
    logic                r_d_valid, w_d_valid_nxt;
    logic                r_timeout_err, w_timeout_err_nxt;
    logic                w_busy, w_expire, w_done, w_grant_i, w_grant_d;
    logic [7:0]          w_cnt_inc;

    assign w_busy    = (r_state != S_IDLE);
    assign w_cnt_inc = r_wait_cnt + 8'd1;
    // Abort on the last permitted ack-less BUSY cycle; an ack in that cycle still wins.
    assign w_expire  = w_busy & ~mem_ack & (w_cnt_inc == LP_MAX_WAIT);
    assign w_done    = w_busy & (mem_ack | w_expire);

    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_grant_d = d_req & (~if_req | ~r_last_d);
                w_grant_i = if_req & ~w_grant_d;
            end
            S_BUSY_I: w_grant_d = w_done & d_req;
            S_BUSY_D: w_grant_i = w_done & if_req;
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_last_d_nxt      = r_last_d;
        w_wait_cnt_nxt    = r_wait_cnt;
        w_mem_req_nxt     = r_mem_req;
        w_mem_we_nxt      = r_mem_we;
        w_mem_addr_nxt    = r_mem_addr;
        w_mem_wdata_nxt   = r_mem_wdata;
        w_if_rdata_nxt    = r_if_rdata;
        w_if_valid_nxt    = 1'b0;
        w_d_rdata_nxt     = r_d_rdata;
        w_d_valid_nxt     = 1'b0;
        w_timeout_err_nxt = r_timeout_err | w_expire;

        if (w_busy) begin
            w_wait_cnt_nxt = w_done ? 8'd0 : w_cnt_inc;
        end

        if (w_done && r_state == S_BUSY_I) begin
            w_if_valid_nxt = 1'b1;
            w_if_rdata_nxt = mem_ack ? mem_rdata : '0;
        end
        if (w_done && r_state == S_BUSY_D) begin
            w_d_valid_nxt = 1'b1;
            // Writes leave the read-data register untouched; aborts clear it.
            if (!mem_ack) begin
                w_d_rdata_nxt = '0;
            end else if (!r_mem_we) begin
                w_d_rdata_nxt = mem_rdata;
            end
        end

        if (w_done) begin
            w_state_nxt   = S_IDLE;
            w_mem_req_nxt = 1'b0;
        end
        if (w_grant_i) begin
            w_state_nxt     = S_BUSY_I;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = ADDR_W'(if_addr);
            w_mem_wdata_nxt = '0;
            w_last_d_nxt    = 1'b0;
        end
        if (w_grant_d) begin
            w_state_nxt     = S_BUSY_D;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = d_we;
            w_mem_addr_nxt  = d_addr;
            w_mem_wdata_nxt = d_wdata;
            w_last_d_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_last_d      <= 1'b1;
            r_wait_cnt    <= 8'd0;
            r_mem_req     <= 1'b0;
            r_mem_we      <= 1'b0;
            r_mem_addr    <= '0;
            r_mem_wdata   <= '0;
            r_if_rdata    <= '0;
            r_if_valid    <= 1'b0;
            r_d_rdata     <= '0;
            r_d_valid     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_last_d      <= w_last_d_nxt;
            r_wait_cnt    <= w_wait_cnt_nxt;
            r_mem_req     <= w_mem_req_nxt;
            r_mem_we      <= w_mem_we_nxt;
            r_mem_addr    <= w_mem_addr_nxt;
            r_mem_wdata   <= w_mem_wdata_nxt;
            r_if_rdata    <= w_if_rdata_nxt;
            r_if_valid    <= w_if_valid_nxt;
            r_d_rdata     <= w_d_rdata_nxt;
            r_d_valid     <= w_d_valid_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_wdata   = r_mem_wdata;
    assign if_rdata    = r_if_rdata;
    assign if_valid    = r_if_valid;
    assign d_rdata     = r_d_rdata;
    assign d_valid     = r_d_valid;
    assign timeout_err = r_timeout_err;
    assign stall       = (if_req & ~r_if_valid) | (d_req & ~r_d_valid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
    localparam int IADDR_W  = 8;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int MAX_WAIT = 15;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               if_req = 1'b0;
    logic [IADDR_W-1:0] if_addr = '0;
    logic [DATA_W-1:0]  if_rdata;
    logic               if_valid;
    logic               d_req = 1'b0;
    logic               d_we = 1'b0;
    logic [ADDR_W-1:0]  d_addr = '0;
    logic [DATA_W-1:0]  d_wdata = '0;
    logic [DATA_W-1:0]  d_rdata;
    logic               d_valid;
    logic               mem_req;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W-1:0]  mem_rdata = '0;
    logic               mem_ack = 1'b0;
    logic               stall;
    logic               timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    mem_port_arbiter #(
        .IADDR_W(IADDR_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall(stall), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rr_exp [4];
    int n;

    initial begin
        rr_exp = '{32'h09, 32'h44, 32'h09, 32'h44};

        // Reset state
        cyc(); cyc();
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_d_valid", 32'(d_valid), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_stall", 32'(stall), 0);
        rst_n = 1'b1;
        cyc();

        // Fetch only, immediate ack
        if_req = 1'b1; if_addr = 8'h05; mem_ack = 1'b1; mem_rdata = 32'h00500093;
        #1;
        chk("f_stall_req", 32'(stall), 1);
        cyc();
        chk("f_mem_req", 32'(mem_req), 1);
        chk("f_mem_addr", mem_addr, 32'h5);
        chk("f_mem_we", 32'(mem_we), 0);
        chk("f_if_valid_early", 32'(if_valid), 0);
        cyc();
        chk("f_if_valid", 32'(if_valid), 1);
        chk("f_if_rdata", if_rdata, 32'h00500093);
        chk("f_stall_done", 32'(stall), 0);
        chk("f_mem_req_off", 32'(mem_req), 0);
        if_req = 1'b0; mem_ack = 1'b0;
        cyc();
        chk("f_if_valid_pulse", 32'(if_valid), 0);

        // Simultaneous requests from reset: fetch first, then data write back-to-back
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        if_req = 1'b1; if_addr = 8'h07;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEADBEEF;
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        cyc();
        chk("s_first_addr", mem_addr, 32'h7);
        chk("s_first_we", 32'(mem_we), 0);
        chk("s_first_wdata", mem_wdata, 0);
        cyc();
        chk("s_b2b_req", 32'(mem_req), 1);
        chk("s_second_addr", mem_addr, 32'h40);
        chk("s_second_we", 32'(mem_we), 1);
        chk("s_second_wdata", mem_wdata, 32'hDEADBEEF);
        chk("s_if_valid", 32'(if_valid), 1);
        chk("s_if_rdata", if_rdata, 32'h11111111);
        if_req = 1'b0;
        cyc();
        chk("s_d_valid", 32'(d_valid), 1);
        chk("s_d_rdata_kept", d_rdata, 0);
        chk("s_mem_req_off", 32'(mem_req), 0);
        d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        cyc();

        // Round-robin with both requests held
        if_req = 1'b1; if_addr = 8'h09; d_req = 1'b1; d_addr = 32'h44;
        mem_ack = 1'b1; mem_rdata = 32'hAAAA0001;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("rr_addr%0d", i), mem_addr, rr_exp[i]);
            chk($sformatf("rr_req%0d", i), 32'(mem_req), 1);
        end
        if_req = 1'b0; d_req = 1'b0;
        cyc();
        chk("rr_d_valid", 32'(d_valid), 1);
        chk("rr_d_rdata", d_rdata, 32'hAAAA0001);
        chk("rr_mem_req_off", 32'(mem_req), 0);
        mem_ack = 1'b0;
        cyc();

        // Wait states: ack in the fourth BUSY cycle
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10; mem_rdata = 32'h1234;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk($sformatf("ws_req%0d", i), 32'(mem_req), 1);
            chk($sformatf("ws_addr%0d", i), mem_addr, 32'h10);
            chk($sformatf("ws_we%0d", i), 32'(mem_we), 0);
            chk($sformatf("ws_stall%0d", i), 32'(stall), 1);
            chk($sformatf("ws_dv%0d", i), 32'(d_valid), 0);
            if (i == 3) mem_ack = 1'b1;
        end
        cyc();
        chk("ws_d_valid", 32'(d_valid), 1);
        chk("ws_d_rdata", d_rdata, 32'h1234);
        chk("ws_mem_req_off", 32'(mem_req), 0);
        d_req = 1'b0; mem_ack = 1'b0;
        cyc();
        chk("ws_d_valid_pulse", 32'(d_valid), 0);

        // Timeout on a never-acked fetch
        if_req = 1'b1; if_addr = 8'h0A;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!if_valid && n < 40);
        if_req = 1'b0;
        chk("to_latency", 32'(n), 32'd16);
        chk("to_if_rdata", if_rdata, 0);
        chk("to_err_set", 32'(timeout_err), 1);
        chk("to_mem_req_off", 32'(mem_req), 0);
        cyc();
        chk("to_if_valid_pulse", 32'(if_valid), 0);
        d_req = 1'b1; d_addr = 32'h20; mem_ack = 1'b1; mem_rdata = 32'h55;
        cyc(); cyc();
        chk("to_ok_d_valid", 32'(d_valid), 1);
        chk("to_ok_d_rdata", d_rdata, 32'h55);
        chk("to_err_sticky", 32'(timeout_err), 1);
        d_req = 1'b0; mem_ack = 1'b0;
        cyc();

        // Asynchronous reset in the middle of a data access
        d_req = 1'b1; d_addr = 32'h30;
        cyc();
        chk("ar_busy_req", 32'(mem_req), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_mem_req", 32'(mem_req), 0);
        chk("ar_d_valid", 32'(d_valid), 0);
        chk("ar_timeout", 32'(timeout_err), 0);
        mem_ack = 1'b1;
        cyc();
        d_req = 1'b0;
        rst_n = 1'b1;
        cyc();
        chk("ar_no_dv0", 32'(d_valid), 0);
        cyc();
        chk("ar_no_dv1", 32'(d_valid), 0);
        if_req = 1'b1; if_addr = 8'h0B; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h50;
        cyc();
        chk("ar_tie_addr", mem_addr, 32'h0B);
        chk("ar_tie_we", 32'(mem_we), 0);
        if_req = 1'b0; d_req = 1'b0;
        cyc(); cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external single-port memory between instruction fetch (IF) and the data access of the MEM stage.
- Uses a request/acknowledge handshake toward memory.
- Round-robin arbitration between the two requesters.
- Registered return data, a per-access wait timeout, and a combinational stall to the pipeline while any requester is unserved.
- Sits between the core's fetch/RAM ports and the shared memory macro or off-chip interface.

Parameters:
- IADDR_W, 8, width of the instruction fetch address.
- ADDR_W, 32, width of the data address and the memory address.
- DATA_W, 32, data width.
- MAX_WAIT, 15, cycles in BUSY without mem_ack before the access is aborted (range 1..255).

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  IADDR_W  fetch word address
- if_rdata  out  DATA_W  fetched instruction, registered
- if_valid  out  1  one-cycle pulse, if_rdata valid
- d_req  in  1  data request, held until d_valid
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_rdata  out  DATA_W  read data, registered
- d_valid  out  1  one-cycle pulse, data access complete
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered; fetch address zero-extended
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completion, sampled while mem_req=1
- stall  out  1  pipeline stall
- timeout_err  out  1  sticky abort flag

Behaviour:
- Reset: state IDLE; last_grant = DATA, so fetch wins the first tie. All outputs 0, wait counter 0. Reset is asynchronous: mem_req drops immediately mid-access, and the in-flight transaction is discarded with no valid pulse.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE: grant on the cycle a request is sampled.
  - Only one request high: that requester wins.
  - Both high: the requester other than last_grant wins.
  - Next cycle: state BUSY_x, mem_req=1, mem_addr/mem_we/mem_wdata latched from the winner, last_grant updated.
  - Fetch grants always drive mem_we=0 and mem_wdata=0.
- BUSY_x, mem_ack=0: hold all mem_* outputs stable; wait counter +1.
- BUSY_x, mem_ack=1:
  - Capture mem_rdata into x_rdata; on data writes d_rdata is left unchanged.
  - Pulse x_valid for exactly the next cycle.
  - Clear the counter.
  - If the other requester's req is high, go directly to its BUSY state (back-to-back, mem_req stays 1, new address latched). Otherwise go to IDLE with mem_req=0.
- Minimum latency: req sampled in cycle N, mem_req in N+1, ack in N+1, valid in N+2.
- Timeout: when the counter reaches MAX_WAIT in BUSY without ack, abort.
  - Pulse x_valid with x_rdata=0.
  - Set timeout_err; it stays set until reset.
  - Counter cleared; next state chosen as for an ack.
- mem_ack is ignored in IDLE, and on the same cycle the counter hits MAX_WAIT the ack takes priority.
- Requester drops req mid-access: the access still completes and the valid still pulses; the requester ignores it.
- A requester re-raising req on the cycle its valid pulses counts as a new request, arbitrated normally.
- stall = (if_req & ~if_valid) | (d_req & ~d_valid), purely combinational.
- Address width rule: mem_addr = {zeros, if_addr} for fetch; d_addr passed unmodified.

Test Plan:
- Reset then fetch only: if_req=1, if_addr=0x05, ack in the first BUSY cycle with mem_rdata=0x00500093 -> mem_addr=0x5, mem_we=0; if_valid pulses 2 cycles after req with if_rdata=0x00500093; stall deasserts that cycle.
- Simultaneous requests from reset: if_req=1, d_req=1, d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, immediate acks -> fetch served first, then data back-to-back with mem_req never dropping; mem_we=1, mem_wdata=0xDEADBEEF; d_rdata unchanged.
- Round-robin fairness: both reqs held continuously for 4 accesses -> grant order I, D, I, D.
- Wait states: data read at 0x10, ack delayed 3 cycles with mem_rdata=0x1234 -> mem_* outputs stable for all 4 BUSY cycles; d_valid=1 and d_rdata=0x1234 exactly one cycle after ack; stall=1 throughout.
- Timeout: MAX_WAIT=15, never ack a fetch -> if_valid pulses after 15 BUSY cycles with if_rdata=0; timeout_err=1 and stays 1 through later successful accesses.
- Async reset mid-access: assert rst_n=0 between clock edges during BUSY_D -> mem_req, valids, and timeout_err go 0 immediately; no d_valid after release; first post-reset tie goes to fetch.
